ex_mem_branch_stage: RTL
========================

Name: ex_mem_branch_stage

Overview:
- Consumer end of the ALU output interface. Registers the ALU result, result2 and flags into the EX/MEM pipeline boundary.
- Resolves conditional branches from the flags and drives the PC redirect.
- Squashes the wrong-path instructions that follow a taken branch with a flush counter.
- Sits between the execute stage (ALU) and the data-memory stage.

Parameters:
- FLUSH_DEPTH, 2, number of incoming instructions squashed after a taken branch (1..7)
- CNT_W, 16, width of the taken-branch performance counter

Ports:
- clk  input  1  stage clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all state and outputs this cycle
- ex_valid  input  1  EX stage presents a valid instruction
- ex_opcod  input  6  opcode of the EX instruction
- ex_pc  input  32  PC of the EX instruction
- ex_offset  input  32  sign-extended branch offset, in words
- ex_result  input  32  ALU result
- ex_result2  input  32  ALU secondary result
- ex_zeroflag  input  1  ALU zero flag
- ex_notequalflag  input  1  ALU not-equal flag
- ex_evenflag  input  1  ALU even flag, taken from result2
- ex_rd  input  5  destination register
- ex_regwrite  input  1  writeback enable
- ex_memread  input  1  load control
- ex_memwrite  input  1  store control
- ex_store_data  input  32  store data
- mem_valid  output  1  MEM-stage instruction valid
- mem_result, mem_result2  output  32 each  registered ALU results
- mem_rd  output  5  registered destination register
- mem_regwrite, mem_memread, mem_memwrite  output  1 each  registered controls, gated by validity
- mem_store_data  output  32  registered store data
- branch_taken  output  1  one-cycle redirect pulse
- branch_target  output  32  redirect PC, valid while branch_taken=1
- flushing  output  1  high while the squash window is open
- taken_count  output  CNT_W  number of taken branches, wraps

Behaviour:
- Reset (asynchronous, takes effect immediately): every output goes to 0, state goes to RUN, flush counter goes to 0. Reset during FLUSH aborts the window. The first post-reset instruction is accepted normally.
- Latency: 1 cycle. Inputs sampled on the rising edge appear on the mem_* outputs after that edge.
- stall=1 has priority over everything except reset:
  - all registers hold, including state, flush counter, taken_count and branch_taken;
  - no input is consumed.
- Branch decode, using package constants:
  - BEQ 000100: taken if ex_zeroflag
  - BNE 000101: taken if ex_notequalflag
  - BEV 001010: taken if ex_evenflag
  - all other opcodes: not a branch
- Accept condition: accept = ex_valid & ~stall & (state==RUN).
- State RUN:
  - On accept: mem_valid=1 and the payload is registered.
  - If the accepted instruction is a branch and taken:
    - branch_taken=1 for exactly one cycle;
    - branch_target = ex_pc + 4 + (ex_offset<<2), computed modulo 2^32;
    - taken_count increments (wraps at 2^CNT_W);
    - flush counter loads FLUSH_DEPTH and state goes to FLUSH.
  - On a non-accepted, non-stalled cycle: mem_valid=0 and branch_taken=0.
- State FLUSH:
  - flushing=1.
  - Each non-stalled cycle with ex_valid=1 squashes that instruction: mem_valid=0, mem_regwrite/mem_memread/mem_memwrite=0, and the counter decrements.
  - A branch arriving while in FLUSH is squashed: no redirect, no count.
  - Cycles with ex_valid=0 do not decrement the counter; the window counts instructions, not cycles.
  - When the counter reaches 0, return to RUN on that edge. The next instruction is accepted.
- Control gating: mem_regwrite, mem_memread and mem_memwrite are always 0 whenever mem_valid=0. Data fields may hold stale values.
- Flag width rules:
  - Flags are single-bit and are trusted as-is.
  - ALU results carrying X on the unused output are registered unchanged. They are never used for decode.
- Branch instructions pass to MEM with regwrite/memread/memwrite exactly as supplied. Decode is responsible for driving them to 0.

Decomposition:
- Package pipe_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_BEV;
  - state encoding ST_RUN, ST_FLUSH;
  - FLUSH_DEPTH default.
- One sub-module, branch_resolve: combinational decode of opcode and flags into taken, plus the target adder. The stage module owns all registers and the FSM.

Test Plan:
- Reset mid-FLUSH with 1 instruction left -> all outputs 0 immediately; state RUN; next ex_valid instruction accepted with mem_valid=1 after 1 edge.
- ALU op, no branch: ex_valid=1, opcod=000000, result=0x0000_0010, rd=5, regwrite=1 -> next cycle mem_valid=1, mem_result=0x10, mem_rd=5, mem_regwrite=1, branch_taken=0.
- BEQ taken: pc=0x0000_0100, offset=0x0000_0003, zeroflag=1 -> branch_taken=1 for exactly one cycle, branch_target=0x0000_0110, taken_count=1, flushing=1; the next 2 valid instructions give mem_valid=0, and the 3rd is accepted.
- BNE not taken (notequalflag=0), then BEV taken with evenflag=1, offset=0xFFFF_FFFF, pc=0x0000_0200 -> no redirect on the first; branch_target=0x0000_0200 on the second.
- Branch during FLUSH: taken BEQ while the counter is 1 -> squashed, no branch_taken, taken_count unchanged; RUN afterwards.
- Stall holds: assert stall for 3 cycles during FLUSH with ex_valid=1 -> counter and outputs unchanged, branch_taken not re-pulsed. Wrap check: taken_count=0xFFFF plus one taken branch -> 0x0000.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the EX/MEM boundary: branch opcodes, stage FSM
// encoding and the default squash depth.
package pipe_pkg;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_BEV = 6'b001010;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam int FLUSH_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/ex_mem_branch_stage_if.sv
// ALU output bundle handed from the execute stage to the EX/MEM boundary.
// The ALU drives the master side; the pipeline register consumes the slave side.
interface ex_mem_branch_stage_if;

    logic        ex_valid;
    logic [5:0]  ex_opcod;
    logic [31:0] ex_pc;
    logic [31:0] ex_offset;
    logic [31:0] ex_result;
    logic [31:0] ex_result2;
    logic        ex_zeroflag;
    logic        ex_notequalflag;
    logic        ex_evenflag;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [31:0] ex_store_data;

    modport master (
        output ex_valid, ex_opcod, ex_pc, ex_offset, ex_result, ex_result2,
               ex_zeroflag, ex_notequalflag, ex_evenflag, ex_rd,
               ex_regwrite, ex_memread, ex_memwrite, ex_store_data
    );

    modport slave (
        input  ex_valid, ex_opcod, ex_pc, ex_offset, ex_result, ex_result2,
               ex_zeroflag, ex_notequalflag, ex_evenflag, ex_rd,
               ex_regwrite, ex_memread, ex_memwrite, ex_store_data
    );

endinterface

// File: rtl/branch_resolve.sv
// Combinational branch decode: turns opcode plus ALU flags into a taken
// decision and computes the word-offset redirect target.
module branch_resolve
    import pipe_pkg::*;
(
    input  logic [5:0]  opcod,
    input  logic [31:0] pc,
    input  logic [31:0] offset,
    input  logic        zeroflag,
    input  logic        notequalflag,
    input  logic        evenflag,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        taken = 1'b0;
        case (opcod)
            OP_BEQ:  taken = zeroflag;
            OP_BNE:  taken = notequalflag;
            OP_BEV:  taken = evenflag;
            default: taken = 1'b0;
        endcase
    end

    // Offset is in words; the add wraps modulo 2^32 by construction.
    assign target = pc + 32'd4 + (offset << 2);

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch resolution, PC redirect and a
// wrong-path squash window counted in incoming instructions.
module ex_mem_branch_stage
    import pipe_pkg::*;
#(
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    ex_mem_branch_stage_if.slave  ex,
    output logic                  mem_valid,
    output logic [31:0]           mem_result,
    output logic [31:0]           mem_result2,
    output logic [4:0]            mem_rd,
    output logic                  mem_regwrite,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic [31:0]           mem_store_data,
    output logic                  branch_taken,
    output logic [31:0]           branch_target,
    output logic                  flushing,
    output logic [CNT_W-1:0]      taken_count
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH);

    state_t      state, state_next;
    logic [2:0]  flush_cnt, flush_cnt_next;
    logic        accept;
    logic        take_branch;
    logic        br_taken;
    logic [31:0] br_target;

    branch_resolve u_resolve (
        .opcod        (ex.ex_opcod),
        .pc           (ex.ex_pc),
        .offset       (ex.ex_offset),
        .zeroflag     (ex.ex_zeroflag),
        .notequalflag (ex.ex_notequalflag),
        .evenflag     (ex.ex_evenflag),
        .taken        (br_taken),
        .target       (br_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            flush_cnt <= 3'd0;
        end else if (!stall) begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // The squash window only advances on valid instructions, never on bubbles.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_RUN: begin
                if (take_branch) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (ex.ex_valid) begin
                    flush_cnt_next = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        accept      = ex.ex_valid && !stall && (state == ST_RUN);
        take_branch = accept && br_taken;
        flushing    = (state == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_result2    <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            mem_store_data <= '0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
            taken_count    <= '0;
        end else if (!stall) begin
            mem_valid    <= accept;
            mem_regwrite <= accept && ex.ex_regwrite;
            mem_memread  <= accept && ex.ex_memread;
            mem_memwrite <= accept && ex.ex_memwrite;
            branch_taken <= take_branch;
            if (accept) begin
                mem_result     <= ex.ex_result;
                mem_result2    <= ex.ex_result2;
                mem_rd         <= ex.ex_rd;
                mem_store_data <= ex.ex_store_data;
            end
            if (take_branch) begin
                branch_target <= br_target;
                taken_count   <= taken_count + 1'b1;
            end
        end
    end

endmodule
